// File: rtl/tdc_pkg.sv
// Shared TDC definitions: summing-stage width, window-size limit and output FSM states.
package tdc_pkg;

    localparam int unsigned TDC_SUM_W  = 20;
    localparam int unsigned LOG2_N_MAX = 8;
    localparam int unsigned OVR_CNT_W  = 8;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/tdc_minmax.sv
// Running min/max tracker for one averaging window; the first sample of a window loads both.
module tdc_minmax
    import tdc_pkg::*;
#(
    parameter int unsigned DATA_W = TDC_SUM_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              sample_en,
    input  logic              first,
    input  logic              last,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] min_c,
    output logic [DATA_W-1:0] max_c
);

    logic [DATA_W-1:0] min_q;
    logic [DATA_W-1:0] max_q;

    // Extremes including the sample presented this cycle.
    assign min_c = (first || (in_data < min_q)) ? in_data : min_q;
    assign max_c = (first || (in_data > max_q)) ? in_data : max_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_q <= '0;
            max_q <= '0;
        end else if (clear) begin
            min_q <= '0;
            max_q <= '0;
        end else if (sample_en) begin
            if (last) begin
                min_q <= '0;
                max_q <= '0;
            end else begin
                min_q <= min_c;
                max_q <= max_c;
            end
        end
    end

endmodule

// File: rtl/tdc_avg_acc.sv
// Windowed averager for summed TDC codes: rounded mean, min and max over 2^LOG2_N samples,
// held in a single-entry output buffer with overrun reporting.
module tdc_avg_acc
    import tdc_pkg::*;
#(
    parameter int unsigned DATA_W = TDC_SUM_W,
    parameter int unsigned LOG2_N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 in_dval,
    input  logic                 clear,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [DATA_W-1:0]    avg_data,
    output logic [DATA_W-1:0]    min_data,
    output logic [DATA_W-1:0]    max_data,
    output logic                 overrun,
    output logic [OVR_CNT_W-1:0] overrun_cnt
);

    localparam int unsigned ACC_W  = DATA_W + LOG2_N + 1;
    localparam int unsigned CNT_W  = LOG2_N + 1;
    localparam int unsigned N      = 32'(1) << LOG2_N;
    localparam int unsigned RND_SH = (LOG2_N == 0) ? 0 : LOG2_N - 1;
    localparam int unsigned ROUND  = (LOG2_N == 0) ? 0 : (32'(1) << RND_SH);

    logic [ACC_W-1:0]  acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ACC_W-1:0]  sum_c;
    logic [DATA_W-1:0] avg_c;
    logic [DATA_W-1:0] min_c;
    logic [DATA_W-1:0] max_c;
    logic              accept_c;
    logic              first_c;
    logic              last_c;
    logic              result_c;
    logic              overrun_c;
    out_state_e        state_q;
    out_state_e        state_d;

    assign accept_c  = in_dval && !clear;
    assign first_c   = (cnt_q == '0);
    assign last_c    = (cnt_q == CNT_W'(N - 1));
    assign result_c  = accept_c && last_c;
    assign overrun_c = result_c && (state_q == OUT_FULL) && !out_ready;
    assign sum_c     = acc_q + ACC_W'(in_data);
    assign avg_c     = DATA_W'((sum_c + ACC_W'(ROUND)) >> LOG2_N);
    assign out_valid = (state_q == OUT_FULL);

    tdc_minmax #(
        .DATA_W (DATA_W)
    ) u_minmax (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .sample_en (accept_c),
        .first     (first_c),
        .last      (last_c),
        .in_data   (in_data),
        .min_c     (min_c),
        .max_c     (max_c)
    );

    // Window accumulator; the closing sample restarts the window on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (in_dval) begin
            if (last_c) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else begin
                acc_q <= sum_c;
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= OUT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            OUT_EMPTY: begin
                if (result_c) begin
                    state_d = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (clear) begin
                    state_d = OUT_EMPTY;
                end else if (!result_c && out_ready) begin
                    state_d = OUT_EMPTY;
                end
            end
            default: state_d = OUT_EMPTY;
        endcase
    end

    // Result registers only change when a new window closes, so they hold under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            avg_data    <= '0;
            min_data    <= '0;
            max_data    <= '0;
            overrun     <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            overrun <= overrun_c;
            if (overrun_c && (overrun_cnt != '1)) begin
                overrun_cnt <= overrun_cnt + OVR_CNT_W'(1);
            end
            if (result_c) begin
                avg_data <= avg_c;
                min_data <= min_c;
                max_data <= max_c;
            end
        end
    end

endmodule

// File: tb/tb_tdc_avg_acc.sv
// Bench for tdc_avg_acc: three instances (N=4, N=16, N=1) share one stimulus stream.
module tb_tdc_avg_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        out_ready;
    logic        in_dval;
    logic [19:0] in_data;

    logic        vld   [3];
    logic        ovr   [3];
    logic [19:0] avg_d [3];
    logic [19:0] min_d [3];
    logic [19:0] max_d [3];
    logic [7:0]  ocnt  [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tdc_avg_acc #(.DATA_W(20), .LOG2_N(2)) u_n4 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_dval(in_dval), .clear(clear),
        .out_ready(out_ready), .out_valid(vld[0]), .avg_data(avg_d[0]), .min_data(min_d[0]),
        .max_data(max_d[0]), .overrun(ovr[0]), .overrun_cnt(ocnt[0]));

    tdc_avg_acc #(.DATA_W(20), .LOG2_N(4)) u_n16 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_dval(in_dval), .clear(clear),
        .out_ready(out_ready), .out_valid(vld[1]), .avg_data(avg_d[1]), .min_data(min_d[1]),
        .max_data(max_d[1]), .overrun(ovr[1]), .overrun_cnt(ocnt[1]));

    tdc_avg_acc #(.DATA_W(20), .LOG2_N(0)) u_n1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_dval(in_dval), .clear(clear),
        .out_ready(out_ready), .out_valid(vld[2]), .avg_data(avg_d[2]), .min_data(min_d[2]),
        .max_data(max_d[2]), .overrun(ovr[2]), .overrun_cnt(ocnt[2]));

    // Reference model: collect each window's samples, then reduce with plain arithmetic.
    int unsigned samp [3][256];
    int          ns   [3];
    bit          m_v  [3];
    bit          m_ov [3];
    int unsigned m_avg[3];
    int unsigned m_min[3];
    int unsigned m_max[3];
    int unsigned m_cnt[3];

    function automatic int l2(int k);
        case (k)
            0:       return 2;
            1:       return 4;
            default: return 0;
        endcase
    endfunction

    function automatic void model_edge();
        for (int k = 0; k < 3; k++) begin
            int          l;
            int          n;
            bit          res;
            longint      s;
            int unsigned mn;
            int unsigned mx;
            int unsigned av;
            l   = l2(k);
            n   = 1 << l;
            res = 0;
            s   = 0;
            mn  = 0;
            mx  = 0;
            av  = 0;
            if (rst) begin
                ns[k] = 0; m_v[k] = 0; m_ov[k] = 0; m_cnt[k] = 0;
                m_avg[k] = 0; m_min[k] = 0; m_max[k] = 0;
            end else if (clear) begin
                ns[k] = 0; m_v[k] = 0; m_ov[k] = 0;
            end else begin
                if (in_dval) begin
                    samp[k][ns[k]] = in_data;
                    ns[k]++;
                    if (ns[k] == n) begin
                        mn = samp[k][0];
                        mx = samp[k][0];
                        for (int i = 0; i < n; i++) begin
                            s += samp[k][i];
                            if (samp[k][i] < mn) mn = samp[k][i];
                            if (samp[k][i] > mx) mx = samp[k][i];
                        end
                        if (l == 0) av = int'(s);
                        else        av = int'((s + (longint'(1) << (l - 1))) / n);
                        res   = 1;
                        ns[k] = 0;
                    end
                end
                m_ov[k] = res && m_v[k] && !out_ready;
                if (m_ov[k] && m_cnt[k] < 255) m_cnt[k]++;
                if (res) begin
                    m_v[k] = 1; m_avg[k] = av; m_min[k] = mn; m_max[k] = mx;
                end else if (m_v[k] && out_ready) begin
                    m_v[k] = 0;
                end
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s.u%0d.valid", tag, k), 32'(vld[k]), 32'(m_v[k]));
            chk($sformatf("%s.u%0d.overrun", tag, k), 32'(ovr[k]), 32'(m_ov[k]));
            chk($sformatf("%s.u%0d.overrun_cnt", tag, k), 32'(ocnt[k]), m_cnt[k]);
            if (m_v[k]) begin
                chk($sformatf("%s.u%0d.avg", tag, k), 32'(avg_d[k]), m_avg[k]);
                chk($sformatf("%s.u%0d.min", tag, k), 32'(min_d[k]), m_min[k]);
                chk($sformatf("%s.u%0d.max", tag, k), 32'(max_d[k]), m_max[k]);
            end
        end
    endtask

    task automatic step(input logic [19:0] d, input bit v, input bit c, input bit r, input bit x,
                        input string tag);
        in_data   = d;
        in_dval   = v;
        clear     = c;
        out_ready = r;
        rst       = x;
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    typedef struct {
        logic [19:0] d;
        bit          v, c, r, x;
        bit          ev;
        logic [19:0] ea, emn, emx;
        bit          eov;
        logic [7:0]  ecnt;
    } vec_t;

    vec_t tv[$];

    function automatic void add(logic [19:0] d, bit v, bit c, bit r, bit x, bit ev,
                                logic [19:0] ea, logic [19:0] emn, logic [19:0] emx,
                                bit eov, logic [7:0] ecnt);
        vec_t e;
        e.d = d; e.v = v; e.c = c; e.r = r; e.x = x; e.ev = ev;
        e.ea = ea; e.emn = emn; e.emx = emx; e.eov = eov; e.ecnt = ecnt;
        tv.push_back(e);
    endfunction

    initial begin
        // Directed vectors with expectations for the N=4 instance.
        add(100, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(101, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(102, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(103, 1, 0, 1, 0, 1, 102, 100, 103, 0, 0);
        add(0,   0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(10,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(10,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(10,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(10,  1, 0, 0, 0, 1, 10, 10, 10, 0, 0);
        add(10,  1, 0, 0, 0, 1, 10, 10, 10, 0, 0);
        add(10,  1, 0, 0, 0, 1, 10, 10, 10, 0, 0);
        add(10,  1, 0, 0, 0, 1, 10, 10, 10, 0, 0);
        add(10,  1, 0, 0, 0, 1, 10, 10, 10, 1, 1);
        add(0,   0, 0, 0, 0, 1, 10, 10, 10, 0, 1);
        add(0,   0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        add(5,   1, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        add(6,   1, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        add(999, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
        add(1,   1, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        add(2,   1, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        add(3,   1, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        add(4,   1, 0, 1, 0, 1, 3, 1, 4, 0, 1);
        add(0,   0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        add(20,  1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(20,  1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(20,  1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(20,  1, 0, 0, 0, 1, 20, 20, 20, 0, 1);
        add(0,   0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        add(8,   1, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        add(8,   1, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        add(8,   1, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        add(0,   0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        add(0,   0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(8,   1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(8,   1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(8,   1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(8,   1, 0, 1, 0, 1, 8, 8, 8, 0, 0);
        add(0,   0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

        in_data = '0; in_dval = 0; clear = 0; out_ready = 0; rst = 1;
        step(0, 0, 0, 0, 1, "reset");
        step(0, 0, 0, 0, 1, "reset");
        step(0, 0, 0, 0, 0, "reset_release");

        foreach (tv[i]) begin
            step(tv[i].d, tv[i].v, tv[i].c, tv[i].r, tv[i].x, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.valid", i), 32'(vld[0]), 32'(tv[i].ev));
            chk($sformatf("vec%0d.overrun", i), 32'(ovr[0]), 32'(tv[i].eov));
            chk($sformatf("vec%0d.overrun_cnt", i), 32'(ocnt[0]), 32'(tv[i].ecnt));
            if (tv[i].ev) begin
                chk($sformatf("vec%0d.avg", i), 32'(avg_d[0]), 32'(tv[i].ea));
                chk($sformatf("vec%0d.min", i), 32'(min_d[0]), 32'(tv[i].emn));
                chk($sformatf("vec%0d.max", i), 32'(max_d[0]), 32'(tv[i].emx));
            end
        end

        // Full-scale window on the N=16 instance.
        step(0, 0, 1, 1, 0, "fs_clear");
        for (int i = 0; i < 16; i++) step(20'hFFFFF, 1, 0, 1, 0, "fullscale");
        chk("fullscale.valid", 32'(vld[1]), 32'd1);
        chk("fullscale.avg", 32'(avg_d[1]), 32'hFFFFF);
        chk("fullscale.min", 32'(min_d[1]), 32'hFFFFF);
        chk("fullscale.max", 32'(max_d[1]), 32'hFFFFF);

        // Pass-through on the N=1 instance: valid for exactly one cycle.
        step(7, 1, 0, 1, 0, "n1_pass");
        chk("n1_pass.valid", 32'(vld[2]), 32'd1);
        chk("n1_pass.avg", 32'(avg_d[2]), 32'd7);
        chk("n1_pass.min", 32'(min_d[2]), 32'd7);
        chk("n1_pass.max", 32'(max_d[2]), 32'd7);
        step(0, 0, 0, 1, 0, "n1_drop");
        chk("n1_drop.valid", 32'(vld[2]), 32'd0);

        for (int i = 0; i < 4000; i++) begin
            logic [19:0] d;
            d = ($urandom_range(0, 1) == 0) ? 20'($urandom_range(0, 15)) : 20'($urandom);
            step(d, ($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 299) == 0), "random");
        end

        // Asynchronous reset: outputs drop to zero before any clock edge.
        step(1, 1, 0, 0, 0, "pre_async");
        in_dval = 0;
        rst     = 1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("async_rst.u%0d.valid", k), 32'(vld[k]), 32'd0);
            chk($sformatf("async_rst.u%0d.avg", k), 32'(avg_d[k]), 32'd0);
            chk($sformatf("async_rst.u%0d.min", k), 32'(min_d[k]), 32'd0);
            chk($sformatf("async_rst.u%0d.max", k), 32'(max_d[k]), 32'd0);
            chk($sformatf("async_rst.u%0d.overrun", k), 32'(ovr[k]), 32'd0);
            chk($sformatf("async_rst.u%0d.overrun_cnt", k), 32'(ocnt[k]), 32'd0);
        end
        step(0, 0, 0, 0, 1, "async_hold");
        step(0, 0, 0, 0, 0, "async_release");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
